// File: rtl/mp_dot_sched.sv
// Purpose : two-requester round-robin scheduler for a shared FP32 / dual-FP16 multiplier.
// Latency : product LAT cycles after issue (dp_capture); res_valid one cycle later.
// Backpr. : at most DEPTH products in flight plus queued; requesters are stalled when full.
//
// Ports:
//   gclk, rst                         clock, async active-high reset
//   reqN_valid/reqN_mode/reqN_ready   requester handshake; mode 1 = FP32, 0 = FP16 split
//   dp_issue/dp_sel/dp_fp32           datapath operand latch, operand mux select, precision
//   dp_capture                        product valid at datapath output
//   res_valid/res_ready/res_id/res_fp32  in-order result handshake with id and mode
//   busy                              scheduler not idle, or work in flight or queued
module mp_dot_sched #(
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic gclk,
    input  logic rst,
    input  logic req0_valid,
    input  logic req0_mode,
    output logic req0_ready,
    input  logic req1_valid,
    input  logic req1_mode,
    output logic req1_ready,
    output logic dp_issue,
    output logic dp_sel,
    output logic dp_fp32,
    output logic dp_capture,
    output logic res_valid,
    input  logic res_ready,
    output logic res_id,
    output logic res_fp32,
    output logic busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          rr_last;     // id granted on the most recent issue
    logic          sel_q;       // operand mux select held between issues
    logic          lock_mode;   // precision the datapath is currently set up for
    logic [CW-1:0] inflight;
    logic [CW-1:0] fifo_cnt;
    logic [LAT-1:0] tag_vld;
    logic [LAT-1:0] tag_id;
    logic [LAT-1:0] tag_mode;
    logic [1:0]    fifo_mem [DEPTH];   // {id, mode}
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          win_vld;
    logic          win_id;
    logic          win_mode;
    logic          credit_ok;
    logic          issue;
    logic          push;
    logic          pop;
    logic [CW:0]   occupancy;

    // Round-robin winner: alternate only when both contend.
    always_comb begin
        win_vld   = req0_valid | req1_valid;
        win_id    = (req0_valid & req1_valid) ? ~rr_last : req1_valid;
        win_mode  = win_id ? req1_mode : req0_mode;
        occupancy = {1'b0, inflight} + {1'b0, fifo_cnt};
        credit_ok = occupancy < DEPTH_W;
        push      = tag_vld[LAT-1];
        pop       = res_valid & res_ready;
    end

    // FSM: state register
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (win_vld && credit_ok) state_nxt = RUN;
            RUN: begin
                // A precision change is never issued from RUN; the pipe empties first.
                if (win_vld) begin
                    if (win_mode != lock_mode) state_nxt = DRAIN;
                end else if (inflight == '0) begin
                    state_nxt = IDLE;
                end
            end
            // Leave once the last in-flight product is being captured.
            DRAIN: if (inflight == CW'(push)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        issue = 1'b0;
        case (state)
            IDLE:    issue = win_vld & credit_ok;
            RUN:     issue = win_vld & credit_ok & (win_mode == lock_mode);
            default: issue = 1'b0;
        endcase
        issue      = issue & ~rst;
        req0_ready = issue & ~win_id;
        req1_ready = issue & win_id;
        dp_issue   = issue;
        dp_sel     = issue ? win_id : sel_q;
        // New precision takes effect in the IDLE issue cycle itself.
        dp_fp32    = (state == IDLE && issue) ? win_mode : lock_mode;
    end

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            rr_last   <= 1'b1;
            sel_q     <= 1'b0;
            lock_mode <= 1'b1;
            inflight  <= '0;
        end else begin
            if (issue) begin
                rr_last <= win_id;
                sel_q   <= win_id;
            end
            if (issue && state == IDLE) lock_mode <= win_mode;
            inflight <= inflight + CW'(issue) - CW'(push);
        end
    end

    // Tag pipeline mirrors the multiplier latency.
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            tag_vld  <= '0;
            tag_id   <= '0;
            tag_mode <= '0;
        end else begin
            tag_vld[0]  <= issue;
            tag_id[0]   <= win_id;
            tag_mode[0] <= win_mode;
            for (int i = 1; i < LAT; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_id[i]   <= tag_id[i-1];
                tag_mode[i] <= tag_mode[i-1];
            end
        end
    end

    // Result FIFO; credits guarantee it never overflows.
    always_ff @(posedge gclk) begin
        if (push) fifo_mem[wr_ptr] <= {tag_id[LAT-1], tag_mode[LAT-1]};
    end

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        dp_capture = tag_vld[LAT-1];
        res_valid  = (fifo_cnt != '0);
        res_id     = res_valid & fifo_mem[rd_ptr][1];
        res_fp32   = res_valid & fifo_mem[rd_ptr][0];
        busy       = (state != IDLE) | (inflight != '0) | res_valid;
    end

endmodule

// File: tb/tb_mp_dot_sched.sv
module tb_mp_dot_sched;

    logic gclk = 1'b0;
    logic rst = 1'b1;
    logic req0_valid = 1'b0, req0_mode = 1'b0, req1_valid = 1'b0, req1_mode = 1'b0;
    logic res_ready = 1'b0;
    logic req0_ready, req1_ready, dp_issue, dp_sel, dp_fp32, dp_capture;
    logic res_valid, res_id, res_fp32, busy;
    logic [9:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    mp_dot_sched #(.LAT(2), .DEPTH(4)) dut (
        .gclk(gclk), .rst(rst),
        .req0_valid(req0_valid), .req0_mode(req0_mode), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_mode(req1_mode), .req1_ready(req1_ready),
        .dp_issue(dp_issue), .dp_sel(dp_sel), .dp_fp32(dp_fp32), .dp_capture(dp_capture),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_fp32(res_fp32),
        .busy(busy)
    );

    always #5 gclk = ~gclk;

    // {r0rdy, r1rdy, issue, sel, fp32, capture, res_valid, res_id, res_fp32, busy}
    assign obs = {req0_ready, req1_ready, dp_issue, dp_sel, dp_fp32,
                  dp_capture, res_valid, res_id, res_fp32, busy};

    task automatic cyc();
        @(posedge gclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        @(negedge gclk);
        n_checks++;
        if (obs !== 10'b0000100000) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, 10'b0000100000);
        end
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [9:0] exp_tbl [5] = '{10'b1010100000, 10'b0000100001, 10'b0000110001,
                                    10'b0000101011, 10'b0000100000};
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req0_valid = (k == 0); req0_mode = 1'b1;
            @(negedge gclk);
            n_checks++;
            if (obs !== exp_tbl[k]) begin
                n_fail++; $display("FAIL single c%0d: got %b want %b", k, obs, exp_tbl[k]);
            end
            cyc();
        end
    endtask

    task automatic test_alternate();
        logic s, eid;
        logic [4:0] e5;
        logic [2:0] e3;
        logic q[$];
        do_reset();
        res_ready = 1'b1; req0_mode = 1'b0; req1_mode = 1'b0;
        for (int k = 0; k < 11; k++) begin
            req0_valid = (k < 8); req1_valid = (k < 8);
            @(negedge gclk);
            s  = k[0];
            e5 = (k < 8) ? {~s, s, 1'b1, s, 1'b0} : 5'b00010;
            n_checks++;
            if ({req0_ready, req1_ready, dp_issue, dp_sel, dp_fp32} !== e5) begin
                n_fail++;
                $display("FAIL alternate_grant c%0d: got %b want %b", k,
                         {req0_ready, req1_ready, dp_issue, dp_sel, dp_fp32}, e5);
            end
            if (k < 8) q.push_back(s);
            if (k >= 3) begin eid = q.pop_front(); e3 = {1'b1, eid, 1'b0}; end
            else e3 = 3'b000;
            n_checks++;
            if ({res_valid, res_id, res_fp32} !== e3) begin
                n_fail++;
                $display("FAIL alternate_result c%0d: got %b want %b", k,
                         {res_valid, res_id, res_fp32}, e3);
            end
            cyc();
        end
    endtask

    task automatic test_drain();
        logic [9:0] exp_tbl [8] = '{10'b1010100000, 10'b0000100001, 10'b0000110001,
                                    10'b0111001011, 10'b0001000001, 10'b0001010001,
                                    10'b0001001101, 10'b0001000000};
        do_reset();
        res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req0_valid = (k == 0);      req0_mode = 1'b1;
            req1_valid = (k >= 1 && k <= 3); req1_mode = 1'b0;
            @(negedge gclk);
            n_checks++;
            if (obs !== exp_tbl[k]) begin
                n_fail++; $display("FAIL drain c%0d: got %b want %b", k, obs, exp_tbl[k]);
            end
            cyc();
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_credit();
        logic iss, cap, rv, bz;
        logic [9:0] e;
        do_reset();
        req0_valid = 1'b1; req0_mode = 1'b1;
        for (int k = 0; k < 11; k++) begin
            res_ready = (k == 8);
            @(negedge gclk);
            iss = (k < 4) || (k == 9);
            cap = (k >= 2) && (k <= 5);
            rv  = (k >= 3);
            bz  = (k > 0);
            e = {iss, 1'b0, iss, 1'b0, 1'b1, cap, rv, 1'b0, rv, bz};
            n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL credit c%0d: got %b want %b", k, obs, e);
            end
            cyc();
        end
        req0_valid = 1'b0; res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic s;
        logic [3:0] e4;
        do_reset();
        req0_mode = 1'b1; req1_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req0_valid = (k < 3);
            @(negedge gclk);
            if (k == 3) begin
                n_checks++;
                if (obs !== 10'b0000111011) begin
                    n_fail++; $display("FAIL mid_prereset: got %b want %b", obs, 10'b0000111011);
                end
            end
            if (k < 3) cyc();
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 10'b0000100000) begin
            n_fail++; $display("FAIL mid_in_reset: got %b want %b", obs, 10'b0000100000);
        end
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge gclk);
            n_checks++;
            if (obs !== 10'b0000100000) begin
                n_fail++; $display("FAIL mid_quiet c%0d: got %b want %b", k, obs, 10'b0000100000);
            end
            cyc();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge gclk);
            s  = k[0];
            e4 = (k < 4) ? {~s, s, 1'b1, s} : 4'b0001;
            n_checks++;
            if ({req0_ready, req1_ready, dp_issue, dp_sel} !== e4) begin
                n_fail++;
                $display("FAIL mid_refill c%0d: got %b want %b", k,
                         {req0_ready, req1_ready, dp_issue, dp_sel}, e4);
            end
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_alternate();
        test_drain();
        test_credit();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mp_dot_sched.md
MP_DOT_SCHED -- requirements
Module: mp_dot_sched

Interface
REQ-001 SHALL have parameter: LAT, 2, cycles from datapath issue to product valid; range 1-8.
REQ-002 SHALL have parameter: DEPTH, 4, result-tag FIFO entries and in-flight credit limit; power of 2, range 2-16.
REQ-003 SHALL have port: gclk  in  1  clock; all state on rising edge.
REQ-004 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: req0_valid / req1_valid  in  1  requester has operand set pending.
REQ-006 SHALL have ports: req0_mode / req1_mode  in  1  1 = FP32 single lane, 0 = FP16 split lanes.
REQ-007 SHALL have ports: req0_ready / req1_ready  out  1  grant; transfer when valid & ready.
REQ-008 SHALL have port: dp_issue  out  1  multiply datapath latches operands this cycle.
REQ-009 SHALL have port: dp_sel  out  1  operand mux select; requester id being issued.
REQ-010 SHALL have port: dp_fp32  out  1  datapath precision mode (drives multiplier en).
REQ-011 SHALL have port: dp_capture  out  1  product valid at datapath output; capture into result buffer.
REQ-012 SHALL have ports: res_valid / res_ready  out / in  1  result handshake.
REQ-013 SHALL have ports: res_id  out  1, res_fp32  out  1  id and mode of the head result.
REQ-014 SHALL have port: busy  out  1  state != IDLE or in-flight != 0 or FIFO non-empty.

Function
REQ-015 SHALL arbitrate round-robin: when both are eligible, grant the requester not granted on the last issue; the pointer updates only on issue.
REQ-016 SHALL assert at most one reqN_ready per cycle; ready combinational from valids, state, credits; ready never depends on the requester's own ready.
REQ-017 SHALL keep credit = DEPTH - (in-flight + FIFO count); issue only when credit > 0; same-cycle issue and pop leave credit unchanged.
REQ-018 SHALL implement FSM with states IDLE, RUN and DRAIN.
REQ-019 IDLE: on the RR winner valid with credit > 0, SHALL latch locked mode = winner mode, issue, and go to RUN.
REQ-020 RUN: SHALL issue the RR winner only if its mode equals locked mode. If the winner's mode differs, SHALL go to DRAIN with no issue that cycle. Other requesters SHALL NOT bypass the winner.
REQ-021 RUN: with no valid request and in-flight = 0, SHALL go to IDLE.
REQ-022 DRAIN: SHALL make no issue; SHALL go to IDLE in the cycle after in-flight reaches 0.
REQ-023 dp_fp32 SHALL equal locked mode and change only on an IDLE-state issue; it holds its value in IDLE.
REQ-024 dp_issue = OR of transfers; dp_sel = granted id, or held at the last value when idle.
REQ-025 SHALL carry tag {valid, id, mode} through a LAT-deep shift register. dp_capture SHALL assert exactly LAT cycles after the issue cycle, and the tag SHALL be pushed into the FIFO at the end of that cycle.
REQ-026 res_valid SHALL equal FIFO non-empty, so it asserts no earlier than LAT+1 cycles after issue. res_id/res_fp32 SHALL come from the head entry and stay stable while res_valid & ~res_ready.
REQ-027 FIFO: pop on res_valid & res_ready; simultaneous push and pop allowed (count unchanged); overflow SHALL be impossible by REQ-017; pointers wrap modulo DEPTH.
REQ-028 Results SHALL leave in issue order regardless of mode.

Reset
REQ-029 While rst=1, SHALL hold: state IDLE; tags, FIFO, in-flight count cleared; credit = DEPTH; the RR pointer set so req0 wins first; locked mode = 1; dp_sel = 0.
REQ-030 While rst=1, all outputs SHALL be 0 except dp_fp32 = 1. Reset mid-operation SHALL discard in-flight and queued results, with no dp_capture or res_valid afterwards until a new issue.

Verification (LAT=2, DEPTH=4)
REQ-031 req0 valid mode=1 at cycle 1 -> issue cycle 1, dp_capture cycle 3, res_valid cycle 4 with res_id=0, res_fp32=1.
REQ-032 Both valid continuously, both mode=0, res_ready=1 -> grants 0,1,0,1,... one issue every cycle, no bubbles.
REQ-033 RUN locked FP32, winner req1 mode=0 -> DRAIN, 2 bubble cycles, then IDLE; req1 issues the following cycle with dp_fp32=0.
REQ-034 res_ready=0, req0 always valid -> 4 issues, then req0_ready=0. Single pop -> exactly one further issue the next cycle.
REQ-035 rst pulse with 2 in flight and 1 queued -> res_valid=0 and dp_capture=0 thereafter; credit=4; the next issue goes to req0.
